// File: rtl/add_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : add_seq_pkg
//  Purpose  : Shared types and constants for the nibble-serial add/sub
//             sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the pass counter never aliases at the last nibble.
    function automatic int cnt_width(input int nibbles);
        return $clog2(nibbles) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder4_ci.sv
`default_nettype none
// ============================================================================
//  Module   : adder4_ci
//  Purpose  : Combinational 4-bit ripple-carry adder with explicit carry-in.
//  Revision : 1.0  initial release
// ============================================================================
module adder4_ci
    import add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : add_seq_ctrl
//  Purpose  : WIDTH-bit add/subtract computed one nibble per clock, LSB first,
//             through a single 4-bit adder slice with valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(NIBBLES - 1);

    state_t                            r_state;
    state_t                            w_next_state;
    logic [CNT_W-1:0]                  r_count;
    logic                              r_carry;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]  r_result;
    logic                              r_carry_out;
    logic                              r_overflow;

    logic [IDX_W-1:0]    w_idx;
    logic [NIBBLE_W-1:0] w_sum;
    logic                w_cout;
    logic                w_last;
    logic                w_accept;
    logic                w_cin_msb;

    assign w_idx    = r_count[IDX_W-1:0];
    assign w_last   = (r_count == c_last);
    assign w_accept = in_valid && in_ready;

    // Only meaningful on the final pass, when the slice is on the MSB nibble.
    assign w_cin_msb = r_a[NIBBLES-1][NIBBLE_W-1] ^ r_b[NIBBLES-1][NIBBLE_W-1]
                     ^ w_sum[NIBBLE_W-1];

    adder4_ci u_adder (
        .a    (r_a[w_idx]),
        .b    (r_b[w_idx]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Subtraction is A + ~B + 1: invert B at capture and seed carry with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_result[w_idx] <= w_sum;
            r_carry         <= w_cout;
            r_count         <= r_count + CNT_W'(1);
            if (w_last) begin
                r_carry_out <= w_cout;
                r_overflow  <= w_cin_msb ^ w_cout;
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_add_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_seq_ctrl
//  Purpose  : Self-checking bench for add_seq_ctrl (WIDTH = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [8];

    add_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic; sub carry means "no borrow" (a >= b).
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] res, output logic co, output logic ov);
        logic [16:0] t;
        if (s) begin
            t   = {1'b0, a} - {1'b0, b};
            co  = (a >= b);
            ov  = (a[15] != b[15]) && (t[15] != a[15]);
        end else begin
            t   = {1'b0, a} + {1'b0, b};
            co  = t[16];
            ov  = (a[15] == b[15]) && (t[15] != a[15]);
        end
        res = t[15:0];
    endtask

    // Entered and left on a negedge; lat counts clock edges from accept to out_valid.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int gap_in, input int gap_out,
                         output logic [15:0] res, output logic co, output logic ov,
                         output int lat);
        int n;
        repeat (gap_in) @(negedge clk);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = result; co = carry_out; ov = overflow;
        repeat (gap_out) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] r, er;
        logic        c, o, ec, eo;
        int          lat;
        int          n;
        logic        seen;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result,    0);
        check("rst_carry_out", carry_out, 0);
        check("rst_overflow",  overflow,  0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, 0, r, c, o, lat);
            check($sformatf("vec%0d_result", i),  r,   vecs[i].res);
            check($sformatf("vec%0d_carry", i),   c,   vecs[i].co);
            check($sformatf("vec%0d_ovf", i),     o,   vecs[i].ov);
            check($sformatf("vec%0d_latency", i), lat, 4);
        end

        // Backpressure in DONE with in_valid pulsing.
        op_a = 16'h1234; op_b = 16'h0FFF; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2);
            op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1;
            @(negedge clk);
            check($sformatf("bp%0d_result", i),    result,    16'h2233);
            check($sformatf("bp%0d_in_ready", i),  in_ready,  0);
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready",  in_ready,  1);
        op_a = 16'h0001; op_b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_accepted", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_latency", n, 4);
        check("b2b_result",  result, 16'h0002);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while RUN has count == 2.
        op_a = 16'h1234; op_b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready",     in_ready,  1);
        check("midrst_out_valid_rl", out_valid, 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", seen, 0);
        do_op(16'h00FF, 16'h0001, 1'b0, 0, 0, r, c, o, lat);
        check("post_rst_result",  r,   16'h0100);
        check("post_rst_carry",   c,   0);
        check("post_rst_ovf",     o,   0);
        check("post_rst_latency", lat, 4);

        // Random regression.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a, b;
            logic        s;
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom);
            model(a, b, s, er, ec, eo);
            do_op(a, b, s, $urandom_range(0, 3), $urandom_range(0, 3), r, c, o, lat);
            check($sformatf("rnd%0d_result", i),  r,   er);
            check($sformatf("rnd%0d_carry", i),   c,   ec);
            check($sformatf("rnd%0d_ovf", i),     o,   eo);
            check($sformatf("rnd%0d_latency", i), lat, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Multi-cycle sequencer that performs WIDTH-bit add/subtract using a single 4-bit adder slice with carry-in, one nibble per clock, LSB first.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.
- Lets the datapath reuse one narrow adder for wide operands, trading latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived count of adder passes; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  controller can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B (two's complement)
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- result  output  WIDTH  sum/difference
- carry_out  output  1  carry out of MSB; for sub, 1 = no borrow
- overflow  output  1  signed overflow

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, count = 0, internal carry = 0.
  - result = 0, carry_out = 0, overflow = 0, out_valid = 0.
  - in_ready = 1 (decoded from state == IDLE).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: latch op_a into a_reg and (sub ? ~op_b : op_b) into b_reg; carry = sub; count = 0; go to RUN.
  - in_valid while not in IDLE is ignored (no request queuing).
- RUN:
  - in_ready = 0.
  - Each cycle, adder slice computes a_reg[4k+3:4k] + b_reg[4k+3:4k] + carry with k = count.
  - Sum nibble is written to result[4k+3:4k]; carry <= slice cout; count increments.
  - On the pass where count == NIBBLES-1:
    - carry_out <= slice cout.
    - overflow <= cin_msb ^ slice cout, where cin_msb = a_reg[W-1] ^ b_reg[W-1] ^ sum[W-1] from that same pass.
    - Go to DONE.
- Latency: out_valid rises exactly NIBBLES clocks after the accepting edge (4 for WIDTH=16).
- DONE:
  - out_valid = 1; result, carry_out and overflow are held stable.
  - On out_ready: go to IDLE next edge, out_valid drops.
  - A new request may be accepted on the first IDLE cycle, so throughput is one op per NIBBLES+2 cycles minimum.
- out_ready while not in DONE is ignored.
- Operands are captured at the accept edge; op_a, op_b and sub may change afterwards without effect.
- result is not cleared between ops; it is only guaranteed valid while out_valid = 1.
- Wrap-around: results are modulo 2^WIDTH; carry_out and overflow carry the lost information.
- Reset mid-RUN or mid-DONE aborts the op immediately:
  - No out_valid is produced.
  - in_ready = 1 once rst_n deasserts.
  - The next op is unaffected.

Decomposition:
- Package add_seq_pkg:
  - state enum (IDLE, RUN, DONE).
  - NIBBLE_W = 4.
  - Counter width function clog2(NIBBLES)+1.
- One sub-module adder4_ci:
  - Combinational 4-bit ripple adder with explicit carry-in.
  - Ports: a[3:0], b[3:0], cin, sum[3:0], cout.
  - Instantiated once; the nibble mux and carry register live in add_seq_ctrl.

Test Plan:
- Add 0x1234 + 0x0FFF, sub = 0 -> result 0x2233, carry_out 0, overflow 0; out_valid exactly 4 cycles after accept.
- Add 0xFFFF + 0x0001 -> result 0x0000, carry_out 1, overflow 0. Add 0x7FFF + 0x0001 -> result 0x8000, carry_out 0, overflow 1.
- Sub 0x0005 - 0x0007 -> result 0xFFFE, carry_out 0, overflow 0. Sub 0x8000 - 0x0001 -> result 0x7FFF, carry_out 1, overflow 1.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE while pulsing in_valid.
  - Required: result stable, in_ready = 0, no new op accepted.
  - Then out_ready = 1 -> IDLE next cycle; a back-to-back request is accepted the following cycle.
- Assert rst_n low during RUN with count = 2.
  - Required: out_valid = 0 and in_ready = 1 on release.
  - A subsequent 0x00FF + 0x0001 -> 0x0100 is correct.
- Random regression of 1000 ops against a reference model:
  - Random sub, in_valid gaps and out_ready gaps.
  - All results, carry_out and overflow match the model; latency is always 4.
